// File: rtl/ni_injector.sv
// Network-interface injector: serialises core packet requests into 8-bit flits for the
// router local input, gated by a credit counter. Optional macro NI_PKT_CNT_EN enables pkt_count.
module ni_injector #(
    parameter int MAX_BODY = 3,
    parameter int CREDITS  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [5:0]                    req_dest,
    input  logic [$clog2(MAX_BODY+1)-1:0] req_len,
    input  logic [6*MAX_BODY-1:0]         req_data,
    output logic [7:0]                    flit_out,
    output logic                          flit_write,
    input  logic                          credit_in,
    output logic                          busy,
    output logic                          credit_err,
    output logic [15:0]                   pkt_count
);

    localparam int LW = $clog2(MAX_BODY + 1);
    localparam int CW = $clog2(CREDITS + 1);
    localparam logic [CW-1:0] CREDIT_MAX = CW'(CREDITS);

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_HEAD = 2'b01;
    localparam logic [1:0] S_BODY = 2'b10;

    logic [1:0]            state;
    logic [5:0]            dest_q;
    logic [LW-1:0]         len_q;
    logic [LW-1:0]         idx_q;
    logic [6*MAX_BODY-1:0] data_q;
    logic [CW-1:0]         credits;

    logic                  issue;
    logic                  last_flit;
    logic [7:0]            next_flit;
    logic [5:0]            payload;

    assign req_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);

    always_comb begin
        payload = '0;
        for (int unsigned n = 0; n < MAX_BODY; n++) begin
            if (idx_q == LW'(n)) begin
                payload = data_q[6*n +: 6];
            end
        end
    end

    // A flit goes out only from HEAD/BODY and only with a credit in hand.
    always_comb begin
        issue     = 1'b0;
        last_flit = 1'b0;
        next_flit = '0;
        case (state)
            S_HEAD: begin
                issue     = (credits != '0);
                last_flit = (len_q == '0);
                next_flit = {(last_flit ? 2'b11 : 2'b01), dest_q};
            end
            S_BODY: begin
                issue     = (credits != '0);
                last_flit = (idx_q == len_q - LW'(1));
                next_flit = {(last_flit ? 2'b10 : 2'b00), payload};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            dest_q <= '0;
            len_q  <= '0;
            idx_q  <= '0;
            data_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        dest_q <= req_dest;
                        len_q  <= req_len;
                        data_q <= req_data;
                        idx_q  <= '0;
                        state  <= S_HEAD;
                    end
                end
                S_HEAD: begin
                    if (issue) begin
                        state <= last_flit ? S_IDLE : S_BODY;
                    end
                end
                S_BODY: begin
                    if (issue) begin
                        if (last_flit) begin
                            state <= S_IDLE;
                        end else begin
                            idx_q <= idx_q + LW'(1);
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flit_out   <= '0;
            flit_write <= 1'b0;
        end else begin
            flit_write <= issue;
            if (issue) begin
                flit_out <= next_flit;
            end
        end
    end

    // Issue and return in the same cycle cancel; a return into a full counter is an error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            credits    <= CREDIT_MAX;
            credit_err <= 1'b0;
        end else begin
            case ({issue, credit_in})
                2'b10: credits <= credits - CW'(1);
                2'b01: begin
                    if (credits == CREDIT_MAX) begin
                        credit_err <= 1'b1;
                    end else begin
                        credits <= credits + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef NI_PKT_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pkt_count <= '0;
        end else if (issue && last_flit) begin
            pkt_count <= pkt_count + 16'd1;
        end
    end
`else
    assign pkt_count = 16'h0000;
`endif

endmodule
